// File: rtl/dmem_responder.sv
// dmem_responder: target end of the RV32I memory-stage load/store interface.
// Accepts one request at a time. After LATENCY cycles it returns a response:
// sign- or zero-extended load data, or a store acknowledge. The response is
// held until the consumer takes it.
// Optional feature macro: DMEM_MMIO_EN adds a word-wide output register at
// MMIO_ADDR, visible on the mmio_out port.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   req_valid/req_ready              request handshake
//   req_write, req_addr, req_wdata   store flag, byte address, store data
//   req_size, req_unsigned           access size (00 b, 01 h, 10 w), zero-extend
//   resp_valid/resp_ready            response handshake
//   resp_rdata, resp_err             load data (0 for stores/errors), error flag
//   mmio_out                         output register (DMEM_MMIO_EN only)
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] MMIO_ADDR   = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
`ifdef DMEM_MMIO_EN
  ,
  output logic [31:0] mmio_out
`endif
);

  localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W      = 4;
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
`ifdef DMEM_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               write_q, write_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic               req_ready_q, req_ready_d;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [31:0]        mem [DEPTH_WORDS];

  logic [IDX_W-1:0]   word_idx_c;
  logic               mmio_hit_c;
  logic               err_c;
  logic [31:0]        mmio_word_c;
  logic [31:0]        src_word_c;
  logic [31:0]        shifted_c;
  logic [15:0]        half_c;
  logic [31:0]        load_c;
  logic [3:0]         wr_be_c;
  logic [31:0]        wr_data_c;
  logic               mem_we_c;

`ifdef DMEM_MMIO_EN
  logic [31:0]        mmio_q, mmio_d;
  assign mmio_word_c = mmio_q;
  assign mmio_out    = mmio_q;
`else
  assign mmio_word_c = '0;
`endif

  // Access decode on the latched request: error checks, lane select, byte enables.
  always_comb begin
    word_idx_c = addr_q[IDX_W+1:2];
    mmio_hit_c = MMIO_EN && (addr_q == MMIO_ADDR);
    err_c      = 1'b0;
    if (req_size_illegal(size_q)) err_c = 1'b1;
    if ((size_q == 2'b01) && addr_q[0]) err_c = 1'b1;
    if ((size_q == 2'b10) && (addr_q[1:0] != 2'b00)) err_c = 1'b1;
    if (({1'b0, addr_q} >= ADDR_LIMIT) && !mmio_hit_c) err_c = 1'b1;
    // The output register is word-only.
    if (mmio_hit_c && (size_q != 2'b10)) err_c = 1'b1;

    src_word_c = mmio_hit_c ? mmio_word_c : mem[word_idx_c];
    shifted_c  = src_word_c >> {addr_q[1:0], 3'b000};
    half_c     = addr_q[1] ? src_word_c[31:16] : src_word_c[15:0];

    case (size_q)
      2'b00:   load_c = uns_q ? {24'h0, shifted_c[7:0]} : {{24{shifted_c[7]}}, shifted_c[7:0]};
      2'b01:   load_c = uns_q ? {16'h0, half_c} : {{16{half_c[15]}}, half_c};
      default: load_c = src_word_c;
    endcase

    case (size_q)
      2'b00:   wr_be_c = 4'b0001 << addr_q[1:0];
      2'b01:   wr_be_c = addr_q[1] ? 4'b1100 : 4'b0011;
      default: wr_be_c = 4'b1111;
    endcase

    case (size_q)
      2'b00:   wr_data_c = {4{wdata_q[7:0]}};
      2'b01:   wr_data_c = {2{wdata_q[15:0]}};
      default: wr_data_c = wdata_q;
    endcase
  end

  function automatic logic req_size_illegal(input logic [1:0] sz);
    return sz == 2'b11;
  endfunction

  // Next-state and registered-output logic for IDLE -> WAIT -> RESP.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    uns_d        = uns_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    mem_we_c     = 1'b0;
`ifdef DMEM_MMIO_EN
    mmio_d       = mmio_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d     = req_write;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          size_d      = req_size;
          uns_d       = req_unsigned;
          cnt_d       = CNT_INIT;
          req_ready_d = 1'b0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          // Execute edge: commit the access and present the response.
          err_d        = err_c;
          rdata_d      = (err_c || write_q) ? 32'h0 : load_c;
          mem_we_c     = write_q && !err_c && !mmio_hit_c && rst_n;
`ifdef DMEM_MMIO_EN
          if (write_q && !err_c && mmio_hit_c) mmio_d = wdata_q;
`endif
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          rdata_d      = 32'h0;
          err_d        = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // Control and request registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

`ifdef DMEM_MMIO_EN
  // Output register.
  always_ff @(posedge clk) begin
    if (!rst_n) mmio_q <= '0;
    else        mmio_q <= mmio_d;
  end
`endif

  // Storage array: byte-lane writes, contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_c[b]) mem[word_idx_c][8*b +: 8] <= wr_data_c[8*b +: 8];
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 1 and 3) sharing request data.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT_A = 1;
  localparam int unsigned LAT_B = 3;
`ifdef DMEM_MMIO_EN
  localparam bit MMIO_ON = 1'b1;
`else
  localparam bit MMIO_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n      [2];
  logic        req_valid  [2];
  logic        resp_ready [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic [31:0] mmio_out   [2];

  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;

  int          total = 0;
  int          bad   = 0;
  int          lat_of [2];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A), .MMIO_ADDR(32'hFFFF_FFF0)) u_dut_a (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
`ifdef DMEM_MMIO_EN
    , .mmio_out(mmio_out[0])
`endif
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_B), .MMIO_ADDR(32'hFFFF_FFF0)) u_dut_b (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
`ifdef DMEM_MMIO_EN
    , .mmio_out(mmio_out[1])
`endif
  );

`ifndef DMEM_MMIO_EN
  assign mmio_out[0] = 32'h0;
  assign mmio_out[1] = 32'h0;
`endif

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [1:0]  sz;
    logic        u;
    logic        e;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[$];

  // Reference model: byte array for the 0x100..0x1FF window plus the output register.
  logic [7:0]  mdl [256];
  logic [31:0] mmio_m;

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] wd,
                              input logic [1:0] sz, input logic u, input logic e,
                              input logic [31:0] rd);
    vec_t v;
    v.w = w; v.a = a; v.wd = wd; v.sz = sz; v.u = u; v.e = e; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic model(input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic u,
                       output logic e, output logic [31:0] rd);
    int          n;
    int          base;
    logic        hit;
    logic [31:0] v;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    hit = MMIO_ON && (a == 32'hFFFF_FFF0);
    if (n == 0) e = 1'b1;
    else e = ((a % n) != 0) || ((a >= 32'(4 * DEPTH)) && !hit) || (hit && n != 4);
    rd = 32'h0;
    if (!e) begin
      if (hit) begin
        if (w) mmio_m = wd;
        else   rd = mmio_m;
      end else begin
        base = int'(a - 32'h100);
        if (w) begin
          for (int i = 0; i < n; i++) mdl[base + i] = wd[8*i +: 8];
        end else begin
          v = 32'h0;
          for (int i = 0; i < n; i++) v = v | (32'(mdl[base + i]) << (8 * i));
          if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
          rd = v;
        end
      end
    end
  endtask

  // One full transaction: accept, latency, response, optional backpressure, consume.
  task automatic do_req(input int inst, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] sz, input logic u,
                        input logic e, input logic [31:0] rd, input int hold,
                        input string name);
    int lat;
    @(negedge clk);
    chk({name, " req_ready idle"}, 32'(req_ready[inst]), 32'd1);
    req_write = w; req_addr = a; req_wdata = wd; req_size = sz; req_unsigned = u;
    req_valid[inst] = 1'b1;
    @(posedge clk); #1;
    req_valid[inst] = 1'b0;
    // Scramble the bus: the responder must use its latched copy.
    req_write = 1'($urandom()); req_addr = $urandom(); req_wdata = $urandom();
    req_size = 2'($urandom()); req_unsigned = 1'($urandom());
    chk({name, " req_ready busy"}, 32'(req_ready[inst]), 32'd0);
    lat = 0;
    while (!resp_valid[inst] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'(lat_of[inst]));
    chk({name, " err"}, 32'(resp_err[inst]), 32'(e));
    chk({name, " rdata"}, resp_rdata[inst], rd);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({name, " held valid"}, 32'(resp_valid[inst]), 32'd1);
      chk({name, " held rdata"}, resp_rdata[inst], rd);
      chk({name, " held req_ready"}, 32'(req_ready[inst]), 32'd0);
    end
    @(negedge clk);
    resp_ready[inst] = 1'b1;
    @(posedge clk); #1;
    resp_ready[inst] = 1'b0;
    chk({name, " consumed valid"}, 32'(resp_valid[inst]), 32'd0);
    chk({name, " ready after consume"}, 32'(req_ready[inst]), 32'd1);
  endtask

  task automatic chk_reset_outs(input int inst, input string name);
    chk({name, " req_ready"}, 32'(req_ready[inst]), 32'd1);
    chk({name, " resp_valid"}, 32'(resp_valid[inst]), 32'd0);
    chk({name, " rdata"}, resp_rdata[inst], 32'h0);
    chk({name, " err"}, 32'(resp_err[inst]), 32'd0);
  endtask

  initial begin
    logic        w, u, e;
    logic [31:0] a, wd, rd;
    logic [1:0]  sz;
    int          kind;

    lat_of[0] = LAT_A;
    lat_of[1] = LAT_B;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; req_valid[i] = 1'b0; resp_ready[i] = 1'b0;
    end
    req_write = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0; req_unsigned = 1'b0;
    mmio_m = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs(0, "reset a");
    chk_reset_outs(1, "reset b");
    chk("reset mmio", mmio_out[0], 32'h0);
    @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // Directed vectors on the LATENCY=1 instance.
    vecs.push_back(mk(1, 32'h10,  32'hDEADBEEF, 2'd2, 0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h10,  32'h0,        2'd2, 0, 0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 32'h10,  32'h0,        2'd0, 0, 0, 32'hFFFFFFEF));
    vecs.push_back(mk(0, 32'h10,  32'h0,        2'd0, 1, 0, 32'h000000EF));
    vecs.push_back(mk(0, 32'h12,  32'h0,        2'd1, 0, 0, 32'hFFFFDEAD));
    vecs.push_back(mk(0, 32'h12,  32'h0,        2'd1, 1, 0, 32'h0000DEAD));
    vecs.push_back(mk(0, 32'h10,  32'h0,        2'd2, 1, 0, 32'hDEADBEEF));
    vecs.push_back(mk(1, 32'h11,  32'h00000055, 2'd0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h10,  32'h0,        2'd2, 0, 0, 32'hDEAD55EF));
    vecs.push_back(mk(1, 32'h13,  32'h0BADF00D, 2'd2, 0, 1, 32'h0));
    vecs.push_back(mk(0, 32'h10,  32'h0,        2'd2, 0, 0, 32'hDEAD55EF));
    vecs.push_back(mk(0, 32'h11,  32'h0,        2'd1, 0, 1, 32'h0));
    vecs.push_back(mk(0, 32'h1000, 32'h0,       2'd2, 0, 1, 32'h0));
    vecs.push_back(mk(1, 32'h1000, 32'h1,       2'd0, 0, 1, 32'h0));
    vecs.push_back(mk(0, 32'h10,  32'h0,        2'd3, 0, 1, 32'h0));
    vecs.push_back(mk(1, 32'h14,  32'h01020304, 2'd2, 0, 0, 32'h0));
    vecs.push_back(mk(1, 32'h16,  32'hFFFF8001, 2'd1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h14,  32'h0,        2'd2, 0, 0, 32'h80010304));
    vecs.push_back(mk(0, 32'h16,  32'h0,        2'd1, 0, 0, 32'hFFFF8001));
    vecs.push_back(mk(0, 32'h16,  32'h0,        2'd1, 1, 0, 32'h00008001));
    vecs.push_back(mk(0, 32'h15,  32'h0,        2'd0, 0, 0, 32'h00000003));
    vecs.push_back(mk(0, 32'h17,  32'h0,        2'd0, 0, 0, 32'hFFFFFF80));
    vecs.push_back(mk(1, 32'hFFC, 32'h7F0000FF, 2'd2, 0, 0, 32'h0));
    vecs.push_back(mk(0, 32'hFFC, 32'h0,        2'd2, 0, 0, 32'h7F0000FF));
    vecs.push_back(mk(0, 32'hFFF, 32'h0,        2'd0, 0, 0, 32'h0000007F));
    vecs.push_back(mk(0, 32'hFFC, 32'h0,        2'd0, 0, 0, 32'hFFFFFFFF));
    vecs.push_back(mk(0, 32'hFFC, 32'h0,        2'd0, 1, 0, 32'h000000FF));
    for (int i = 0; i < vecs.size(); i++) begin
      do_req(0, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].sz, vecs[i].u,
             vecs[i].e, vecs[i].rd, 0, $sformatf("vec%0d", i));
    end

`ifdef DMEM_MMIO_EN
    do_req(0, 1, 32'hFFFF_FFF0, 32'hCAFE0001, 2'd2, 0, 0, 32'h0, 0, "mmio sw");
    chk("mmio_out after sw", mmio_out[0], 32'hCAFE0001);
    do_req(0, 0, 32'hFFFF_FFF0, 32'h0, 2'd2, 0, 0, 32'hCAFE0001, 0, "mmio lw");
    do_req(0, 1, 32'hFFFF_FFF0, 32'h000000AA, 2'd0, 0, 1, 32'h0, 0, "mmio sb");
    chk("mmio_out after sb", mmio_out[0], 32'hCAFE0001);
    mmio_m = 32'hCAFE0001;
`else
    do_req(0, 0, 32'hFFFF_FFF0, 32'h0, 2'd2, 0, 1, 32'h0, 0, "mmio addr absent");
`endif

    // LATENCY=3 instance: backpressure, then reset mid-WAIT and in RESP.
    do_req(1, 1, 32'h20, 32'h11111111, 2'd2, 0, 0, 32'h0, 0, "b sw");
    do_req(1, 0, 32'h20, 32'h0, 2'd2, 0, 0, 32'h11111111, 5, "b backpressure");

    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_size = 2'd2;
    req_unsigned = 1'b0; req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n[1] = 1'b0;
    @(posedge clk); #1;
    chk_reset_outs(1, "rst wait");
    @(negedge clk);
    rst_n[1] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst wait no resp", 32'(resp_valid[1]), 32'd0);
    do_req(1, 0, 32'h20, 32'h0, 2'd2, 0, 0, 32'h11111111, 0, "b after rst");

    @(negedge clk);
    req_write = 1'b0; req_addr = 32'h20; req_size = 2'd2; req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    repeat (LAT_B) @(posedge clk);
    #1;
    chk("resp pending", 32'(resp_valid[1]), 32'd1);
    @(negedge clk);
    rst_n[1] = 1'b0;
    @(posedge clk); #1;
    chk_reset_outs(1, "rst resp");
    @(negedge clk);
    rst_n[1] = 1'b1;

    // Randomized traffic on the LATENCY=1 instance against the model.
    for (int k = 0; k < 64; k++) begin
      a  = 32'h100 + 32'(4 * k);
      wd = $urandom();
      model(1'b1, a, wd, 2'd2, 1'b0, e, rd);
      do_req(0, 1'b1, a, wd, 2'd2, 1'b0, e, rd, 0, "fill");
    end
    for (int k = 0; k < 300; k++) begin
      kind = int'($urandom_range(0, 9));
      case (kind)
        0:       a = 32'h1000 + 32'($urandom_range(0, 15));
        1:       a = 32'hFFFF_FFF0;
        2:       a = {1'b1, 31'($urandom())};
        default: a = 32'h100 + 32'($urandom_range(0, 255));
      endcase
      w  = 1'($urandom());
      wd = $urandom();
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      u  = 1'($urandom());
      model(w, a, wd, sz, u, e, rd);
      do_req(0, w, a, wd, sz, u, e, rd, int'($urandom_range(0, 3)), $sformatf("rnd%0d", k));
    end
`ifdef DMEM_MMIO_EN
    chk("mmio_out final", mmio_out[0], mmio_m);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
